// File: rtl/aes_pkcs7_pad.sv
// AXIS PKCS#7 padder in front of the AES-128 ECB core: key beats pass verbatim, plaintext is padded to 16-byte blocks.
// Define AES_PKCS7_ERR_EN to add the sticky Err output for malformed tlast/tkeep framing.
module aes_pkcs7_pad #(
    parameter int AXIS_WIDTH = 32
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [AXIS_WIDTH-1:0]   S_axis_tdata,
    input  logic [AXIS_WIDTH/8-1:0] S_axis_tkeep,
    input  logic                    S_axis_tvalid,
    output logic                    S_axis_tready,
    input  logic                    S_axis_tlast,
    output logic [AXIS_WIDTH-1:0]   M_axis_tdata,
    output logic [AXIS_WIDTH/8-1:0] M_axis_tkeep,
    output logic                    M_axis_tvalid,
    input  logic                    M_axis_tready,
    output logic                    M_axis_tlast
`ifdef AES_PKCS7_ERR_EN
    ,
    output logic                    Err
`endif
);

    localparam int BYTES       = AXIS_WIDTH / 8;
    localparam int BLOCK_BEATS = 128 / AXIS_WIDTH;
    localparam int CNT_W       = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam int PAD_W       = $clog2(BLOCK_BEATS + 1);

    typedef enum logic [1:0] {
        ST_KEY  = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    function automatic logic [4:0] popcount(input logic [BYTES-1:0] keep);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < BYTES; i++) begin
            cnt = cnt + {4'd0, keep[i]};
        end
        return cnt;
    endfunction

    // Pad value from the byte position inside the current 16-byte block; a block-aligned end yields 16.
    function automatic logic [4:0] pad_value(input logic [CNT_W-1:0] cnt, input logic [4:0] n);
        logic [4:0] pos;
        pos = 5'((int'(cnt) * BYTES + int'(n)) % 16);
        return 5'd16 - pos;
    endfunction

    function automatic logic [AXIS_WIDTH-1:0] pad_beat(input logic [AXIS_WIDTH-1:0] data,
                                                       input logic [4:0]            n,
                                                       input logic [4:0]            p);
        logic [AXIS_WIDTH-1:0] res;
        res = data;
        for (int i = 0; i < BYTES; i++) begin
            if (5'(i) >= n) begin
                res[8*i +: 8] = {3'b000, p};
            end
        end
        return res;
    endfunction

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      key_cnt;
    logic [CNT_W-1:0]      beat_cnt;
    logic [PAD_W-1:0]      pad_cnt;
    logic [4:0]            pad_p;

    logic                  out_ready;
    logic                  s_xfer;
    logic                  load;
    logic [4:0]            n_in;
    logic [4:0]            p_in;
    logic                  full_beat;
    logic                  last_in_blk;
    logic                  close_blk;
    logic [AXIS_WIDTH-1:0] data_nxt;
    logic                  last_nxt;

    logic                  vld_p1;
    logic                  last_p1;
    logic [AXIS_WIDTH-1:0] data_p1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_KEY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_KEY: begin
                if (s_xfer && key_cnt == '0) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s_xfer && S_axis_tlast) begin
                    state_nxt = close_blk ? ST_KEY : ST_PAD;
                end
            end
            ST_PAD: begin
                if (out_ready && pad_cnt == PAD_W'(1)) begin
                    state_nxt = ST_KEY;
                end
            end
            default: state_nxt = ST_KEY;
        endcase
    end

    // A short last beat in the final block slot closes the block itself; anything else needs pad beats.
    always_comb begin
        out_ready     = ~vld_p1 | M_axis_tready;
        S_axis_tready = (state != ST_PAD) & out_ready;
        s_xfer        = S_axis_tvalid & S_axis_tready;
        n_in          = popcount(S_axis_tkeep);
        p_in          = pad_value(beat_cnt, n_in);
        full_beat     = (n_in == 5'(BYTES));
        last_in_blk   = (beat_cnt == CNT_W'(BLOCK_BEATS - 1));
        close_blk     = ~full_beat & last_in_blk;
        load          = out_ready & (s_xfer | (state == ST_PAD));
        data_nxt      = S_axis_tdata;
        last_nxt      = 1'b0;
        case (state)
            ST_DATA: begin
                if (S_axis_tlast) begin
                    data_nxt = pad_beat(S_axis_tdata, n_in, p_in);
                    last_nxt = close_blk;
                end
            end
            ST_PAD: begin
                data_nxt = {BYTES{{3'b000, pad_p}}};
                last_nxt = (pad_cnt == PAD_W'(1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            key_cnt  <= CNT_W'(BLOCK_BEATS - 1);
            beat_cnt <= '0;
            pad_cnt  <= '0;
            pad_p    <= '0;
        end else begin
            case (state)
                ST_KEY: begin
                    if (s_xfer) begin
                        if (key_cnt == '0) begin
                            beat_cnt <= '0;
                        end else begin
                            key_cnt <= key_cnt - 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_xfer) begin
                        if (S_axis_tlast) begin
                            key_cnt <= CNT_W'(BLOCK_BEATS - 1);
                            pad_p   <= p_in;
                            if (full_beat && last_in_blk) begin
                                pad_cnt <= PAD_W'(BLOCK_BEATS);
                            end else begin
                                pad_cnt <= PAD_W'(BLOCK_BEATS - 1 - int'(beat_cnt));
                            end
                        end else if (last_in_blk) begin
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    if (out_ready) begin
                        pad_cnt <= pad_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- stage p1: output register toward the cipher core ----
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            data_p1 <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            last_p1 <= last_nxt;
            data_p1 <= data_nxt;
        end else if (M_axis_tready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign M_axis_tvalid = vld_p1;
    assign M_axis_tdata  = data_p1;
    assign M_axis_tlast  = last_p1;
    assign M_axis_tkeep  = {BYTES{vld_p1}};

`ifdef AES_PKCS7_ERR_EN
    function automatic logic keep_contig(input logic [BYTES-1:0] keep);
        return ((keep & (keep + BYTES'(1))) == '0);
    endfunction

    logic err_hit;

    always_comb begin
        err_hit = 1'b0;
        if (s_xfer) begin
            case (state)
                ST_KEY:  err_hit = S_axis_tlast;
                ST_DATA: err_hit = S_axis_tlast ? ~keep_contig(S_axis_tkeep)
                                                : (S_axis_tkeep != '1);
                default: err_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Err <= 1'b0;
        end else if (err_hit) begin
            Err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_pkcs7_pad.sv
// Scoreboard bench for aes_pkcs7_pad at AXIS_WIDTH=32: directed PKCS#7 vectors, random backpressure, reset in padding.
module tb_aes_pkcs7_pad;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] S_axis_tdata;
    logic [3:0]  S_axis_tkeep;
    logic        S_axis_tvalid;
    logic        S_axis_tready;
    logic        S_axis_tlast;
    logic [31:0] M_axis_tdata;
    logic [3:0]  M_axis_tkeep;
    logic        M_axis_tvalid;
    logic        M_axis_tready;
    logic        M_axis_tlast;
`ifdef AES_PKCS7_ERR_EN
    logic        Err;
`endif

    aes_pkcs7_pad #(.AXIS_WIDTH(32)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .S_axis_tdata  (S_axis_tdata),
        .S_axis_tkeep  (S_axis_tkeep),
        .S_axis_tvalid (S_axis_tvalid),
        .S_axis_tready (S_axis_tready),
        .S_axis_tlast  (S_axis_tlast),
        .M_axis_tdata  (M_axis_tdata),
        .M_axis_tkeep  (M_axis_tkeep),
        .M_axis_tvalid (M_axis_tvalid),
        .M_axis_tready (M_axis_tready),
        .M_axis_tlast  (M_axis_tlast)
`ifdef AES_PKCS7_ERR_EN
        ,
        .Err           (Err)
`endif
    );

    always #5 Clk = ~Clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    bit           mon_en   = 1'b0;
    bit           rnd_rdy  = 1'b0;
    logic [32:0]  exp_q[$];
    byte unsigned msg_q[$];
    logic [31:0]  key_beats[4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    // Output monitor: a beat transfers on the next rising edge when valid and ready are both high here.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge Clk);
            if (mon_en && M_axis_tvalid === 1'b1 && M_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_extra: got %h last=%b, expected no beat", M_axis_tdata, M_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat{last,data}", {31'd0, M_axis_tlast, M_axis_tdata}, {31'd0, e});
                    check("out_tkeep", {60'd0, M_axis_tkeep}, 64'hF);
                end
            end
        end
    end

    initial begin
        M_axis_tready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            M_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input int gap);
        bit acc;
        int t;
        idle(gap);
        S_axis_tdata  = d;
        S_axis_tkeep  = k;
        S_axis_tlast  = l;
        S_axis_tvalid = 1'b1;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 500) begin
            @(negedge Clk);
            if (S_axis_tready) acc = 1'b1;
            @(posedge Clk);
            #1;
            t++;
        end
        S_axis_tvalid = 1'b0;
        S_axis_tlast  = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_handshake: got no tready in 500 cycles, expected acceptance");
        end
    endtask

    task automatic expect_key();
        for (int i = 0; i < 4; i++) push_exp(key_beats[i], 1'b0);
    endtask

    task automatic send_key(input int tlast_at, input int gapmax);
        for (int i = 0; i < 4; i++)
            send_beat(key_beats[i], 4'hF, (i == tlast_at), $urandom_range(0, gapmax));
    endtask

    // Software PKCS#7 reference over the bytes in msg_q.
    task automatic expect_msg();
        byte unsigned pq[$];
        int           p;
        int           nb;
        logic [31:0]  d;
        pq = msg_q;
        p  = 16 - (msg_q.size() % 16);
        repeat (p) pq.push_back(8'(p));
        nb = pq.size() / 4;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 4; j++) d[8*j +: 8] = pq[4*b + j];
            push_exp(d, (b == nb - 1));
        end
    endtask

    task automatic send_msg(input int gapmax);
        int          len;
        int          nb;
        int          idx;
        logic [31:0] d;
        logic [3:0]  k;
        len = msg_q.size();
        nb  = (len == 0) ? 1 : (len + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            d = $urandom();
            k = 4'h0;
            for (int j = 0; j < 4; j++) begin
                idx = 4*b + j;
                if (idx < len) begin
                    d[8*j +: 8] = msg_q[idx];
                    k[j] = 1'b1;
                end
            end
            send_beat(d, k, (b == nb - 1), $urandom_range(0, gapmax));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge Clk);
            #1;
            t++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
        idle(2);
    endtask

    initial begin
        Rst = 1'b1;
        S_axis_tdata = '0;
        S_axis_tkeep = '0;
        S_axis_tvalid = 1'b0;
        S_axis_tlast = 1'b0;
        idle(3);
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_m_tvalid", {63'd0, M_axis_tvalid}, 64'd0);
        check("rst_m_tdata", {32'd0, M_axis_tdata}, 64'd0);
        check("rst_m_tkeep", {60'd0, M_axis_tkeep}, 64'd0);
        check("rst_m_tlast", {63'd0, M_axis_tlast}, 64'd0);
        check("rst_s_tready", {63'd0, S_axis_tready}, 64'd1);
`ifdef AES_PKCS7_ERR_EN
        check("rst_err", {63'd0, Err}, 64'd0);
`endif
        @(posedge Clk);
        #1;
        mon_en = 1'b1;

        // 3-byte message: pad 13 bytes of 0x0D
        expect_key();
        push_exp(32'h0DCCBBAA, 1'b0);
        push_exp(32'h0D0D0D0D, 1'b0);
        push_exp(32'h0D0D0D0D, 1'b0);
        push_exp(32'h0D0D0D0D, 1'b1);
        send_key(-1, 0);
        send_beat(32'h00CCBBAA, 4'b0111, 1'b1, 0);

        // 16-byte message: full extra block of 0x10, input stalled throughout padding
        expect_key();
        push_exp(32'h13121110, 1'b0);
        push_exp(32'h17161514, 1'b0);
        push_exp(32'h1B1A1918, 1'b0);
        push_exp(32'h1F1E1D1C, 1'b0);
        for (int i = 0; i < 3; i++) push_exp(32'h10101010, 1'b0);
        push_exp(32'h10101010, 1'b1);
        send_key(-1, 0);
        send_beat(32'h13121110, 4'hF, 1'b0, 0);
        send_beat(32'h17161514, 4'hF, 1'b0, 0);
        send_beat(32'h1B1A1918, 4'hF, 1'b0, 0);
        send_beat(32'h1F1E1D1C, 4'hF, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("pad_s_tready", {63'd0, S_axis_tready}, 64'd0);
            @(posedge Clk);
            #1;
        end
        @(negedge Clk);
        check("post_pad_s_tready", {63'd0, S_axis_tready}, 64'd1);
        @(posedge Clk);
        #1;

        // 15-byte message closes the block itself, then a 2-byte packet back-to-back
        expect_key();
        push_exp(32'h23222120, 1'b0);
        push_exp(32'h27262524, 1'b0);
        push_exp(32'h2B2A2928, 1'b0);
        push_exp(32'h01EEDDCC, 1'b1);
        expect_key();
        push_exp(32'h0E0E7788, 1'b0);
        push_exp(32'h0E0E0E0E, 1'b0);
        push_exp(32'h0E0E0E0E, 1'b0);
        push_exp(32'h0E0E0E0E, 1'b1);
        send_key(-1, 0);
        send_beat(32'h23222120, 4'hF, 1'b0, 0);
        send_beat(32'h27262524, 4'hF, 1'b0, 0);
        send_beat(32'h2B2A2928, 4'hF, 1'b0, 0);
        send_beat(32'h00EEDDCC, 4'b0111, 1'b1, 0);
        send_key(-1, 0);
        send_beat(32'h55667788, 4'b0011, 1'b1, 0);

        // empty message: one block of 0x10
        expect_key();
        for (int i = 0; i < 3; i++) push_exp(32'h10101010, 1'b0);
        push_exp(32'h10101010, 1'b1);
        send_key(-1, 0);
        send_beat(32'hDEADBEEF, 4'b0000, 1'b1, 0);

        // 4-byte message: full beat not ending a block, 12 bytes of 0x0C
        expect_key();
        push_exp(32'h44332211, 1'b0);
        push_exp(32'h0C0C0C0C, 1'b0);
        push_exp(32'h0C0C0C0C, 1'b0);
        push_exp(32'h0C0C0C0C, 1'b1);
        send_key(-1, 0);
        send_beat(32'h44332211, 4'hF, 1'b1, 0);
        drain();
`ifdef AES_PKCS7_ERR_EN
        check("err_clean_traffic", {63'd0, Err}, 64'd0);
`endif

        // random backpressure and source gaps against the software model
        rnd_rdy = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int len;
            len = $urandom_range(0, 40);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
            expect_key();
            expect_msg();
            send_key(-1, 2);
            send_msg(2);
        end
        drain();
        rnd_rdy = 1'b0;
        idle(2);

        // reset while padding: partial packet dropped
        mon_en = 1'b0;
        send_key(-1, 0);
        send_beat(32'h00CCBBAA, 4'b0111, 1'b1, 0);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("midrst_m_tvalid", {63'd0, M_axis_tvalid}, 64'd0);
        check("midrst_m_tdata", {32'd0, M_axis_tdata}, 64'd0);
        check("midrst_s_tready", {63'd0, S_axis_tready}, 64'd1);
        @(posedge Clk);
        #1;
        exp_q.delete();
        mon_en = 1'b1;

        // next four beats are key; tlast on key beat 2 is not forwarded
        expect_key();
        push_exp(32'h0DCCBBAA, 1'b0);
        push_exp(32'h0D0D0D0D, 1'b0);
        push_exp(32'h0D0D0D0D, 1'b0);
        push_exp(32'h0D0D0D0D, 1'b1);
        send_key(2, 0);
        send_beat(32'h00CCBBAA, 4'b0111, 1'b1, 0);
        drain();
`ifdef AES_PKCS7_ERR_EN
        check("err_key_tlast", {63'd0, Err}, 64'd1);
        expect_key();
        push_exp(32'h0DCCBBAA, 1'b0);
        push_exp(32'h0D0D0D0D, 1'b0);
        push_exp(32'h0D0D0D0D, 1'b0);
        push_exp(32'h0D0D0D0D, 1'b1);
        send_key(-1, 0);
        send_beat(32'h00CCBBAA, 4'b0111, 1'b1, 0);
        drain();
        check("err_sticky", {63'd0, Err}, 64'd1);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("err_cleared", {63'd0, Err}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
